ucie_rdi_state_hs_mc: RTL and testbench

// Multi-channel RDI state-request/stall handshake engine on the physical-layer side of RDI, one independent FSM per channel.

---
 rtl/ucie_rdi_state_hs_mc.sv | 179 +++++++++++++++++
 tb/tb_ucie_rdi_state_hs_mc.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_rdi_state_hs_mc.sv
// Multi-channel RDI state-request / stall-handshake engine (physical-layer side).
// Each channel runs an independent FSM with stall timeout and a saturating LinkError counter.
module ucie_rdi_state_hs_mc #(
  parameter int NUM_CH        = 4,
  parameter int STALL_TIMEOUT = 1024,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_CH-1:0]           lp_state_req,
  input  logic [NUM_CH-1:0]             lp_stallack,
  input  logic [NUM_CH-1:0]             phy_link_up,
  input  logic [NUM_CH-1:0]             phy_link_err,
  output logic [NUM_CH-1:0]             pl_stallreq,
  output logic [4*NUM_CH-1:0]           pl_state_sts,
  output logic [NUM_CH-1:0]             link_up,
  output logic [NUM_CH-1:0]             stall_busy,
  output logic [NUM_CH-1:0]             timeout_pulse,
  output logic [ERR_CNT_W*NUM_CH-1:0]   err_cnt
);

  localparam int TMR_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STALL_TIMEOUT - 1);

  localparam logic [3:0] ST_RESET     = 4'h0;
  localparam logic [3:0] ST_ACTIVE    = 4'h1;
  localparam logic [3:0] ST_L1        = 4'h4;
  localparam logic [3:0] ST_L2        = 4'h8;
  localparam logic [3:0] ST_LINKRESET = 4'h9;
  localparam logic [3:0] ST_LINKERROR = 4'hA;
  localparam logic [3:0] ST_RETRAIN   = 4'hB;

  typedef enum logic [2:0] {
    S_RESET, S_ACTIVE, S_STALL_REQ, S_STALL_REL, S_PARKED, S_ERROR
  } state_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic is_stall_tgt(input logic [3:0] r);
    return (r == ST_L1) || (r == ST_L2) || (r == ST_LINKRESET) || (r == ST_RETRAIN);
  endfunction

  // L1 and Retrain resume to ACTIVE; L2 and LinkReset fall back to RESET.
  function automatic logic resumes_active(input logic [3:0] t);
    return (t == ST_L1) || (t == ST_RETRAIN);
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [3:0]           req_p0;
    logic                 ack_p0, up_p0, err_p0;
    state_t               state_p1, state_nxt;
    logic [3:0]           target_p1, target_nxt;
    logic [TMR_W-1:0]     timer_p1, timer_nxt;
    logic                 tmo;
    logic                 stallreq_d, busy_d, link_up_d, tmo_d;
    logic [3:0]           sts_d;
    logic [ERR_CNT_W-1:0] err_d;
    logic                 stallreq_p1, busy_p1, link_up_p1, tmo_p1;
    logic [3:0]           sts_p1;
    logic [ERR_CNT_W-1:0] err_p1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        req_p0      <= ST_RESET;
        ack_p0      <= 1'b0;
        up_p0       <= 1'b0;
        err_p0      <= 1'b0;
        state_p1    <= S_RESET;
        target_p1   <= ST_RESET;
        timer_p1    <= '0;
        stallreq_p1 <= 1'b0;
        busy_p1     <= 1'b0;
        link_up_p1  <= 1'b0;
        tmo_p1      <= 1'b0;
        sts_p1      <= ST_RESET;
        err_p1      <= '0;
      end else begin
        // p0: input capture
        req_p0      <= lp_state_req[4*c +: 4];
        ack_p0      <= lp_stallack[c];
        up_p0       <= phy_link_up[c];
        err_p0      <= phy_link_err[c];
        // p1: FSM state and registered outputs
        state_p1    <= state_nxt;
        target_p1   <= target_nxt;
        timer_p1    <= timer_nxt;
        stallreq_p1 <= stallreq_d;
        busy_p1     <= busy_d;
        link_up_p1  <= link_up_d;
        tmo_p1      <= tmo_d;
        sts_p1      <= sts_d;
        err_p1      <= err_d;
      end
    end

    always_comb begin
      state_nxt  = state_p1;
      target_nxt = target_p1;
      timer_nxt  = timer_p1;
      tmo        = 1'b0;
      if (err_p0 && (state_p1 != S_RESET) && (state_p1 != S_ERROR)) begin
        state_nxt = S_ERROR;
      end else begin
        case (state_p1)
          S_RESET: begin
            if ((req_p0 == ST_ACTIVE) && up_p0 && !err_p0) state_nxt = S_ACTIVE;
          end
          S_ACTIVE: begin
            if (is_stall_tgt(req_p0)) begin
              target_nxt = req_p0;
              timer_nxt  = '0;
              state_nxt  = S_STALL_REQ;
            end else if (!up_p0) begin
              target_nxt = ST_RETRAIN;
              timer_nxt  = '0;
              state_nxt  = S_STALL_REQ;
            end
          end
          S_STALL_REQ: begin
            if (ack_p0) begin
              timer_nxt = '0;
              state_nxt = S_STALL_REL;
            end else if (timer_p1 == TMR_LAST) begin
              tmo       = 1'b1;
              state_nxt = S_ERROR;
            end else begin
              timer_nxt = timer_p1 + 1'b1;
            end
          end
          S_STALL_REL: begin
            if (!ack_p0) begin
              state_nxt = S_PARKED;
            end else if (timer_p1 == TMR_LAST) begin
              tmo       = 1'b1;
              state_nxt = S_ERROR;
            end else begin
              timer_nxt = timer_p1 + 1'b1;
            end
          end
          S_PARKED: begin
            if (resumes_active(target_p1)) begin
              if ((req_p0 == ST_ACTIVE) && up_p0) state_nxt = S_ACTIVE;
            end else if (req_p0 == ST_RESET) begin
              state_nxt = S_RESET;
            end
          end
          S_ERROR: begin
            if ((req_p0 == ST_RESET) && !err_p0) state_nxt = S_RESET;
          end
          default: state_nxt = S_RESET;
        endcase
      end
    end

    always_comb begin
      stallreq_d = (state_nxt == S_STALL_REQ);
      busy_d     = (state_nxt == S_STALL_REQ) || (state_nxt == S_STALL_REL);
      case (state_nxt)
        S_ACTIVE, S_STALL_REQ, S_STALL_REL: sts_d = ST_ACTIVE;
        S_PARKED:                           sts_d = target_nxt;
        S_ERROR:                            sts_d = ST_LINKERROR;
        default:                            sts_d = ST_RESET;
      endcase
      link_up_d = (sts_d == ST_ACTIVE);
      tmo_d     = tmo;
      err_d     = ((state_nxt == S_ERROR) && (state_p1 != S_ERROR)) ? sat_inc(err_p1) : err_p1;
    end

    assign pl_stallreq[c]                     = stallreq_p1;
    assign stall_busy[c]                      = busy_p1;
    assign link_up[c]                         = link_up_p1;
    assign timeout_pulse[c]                   = tmo_p1;
    assign pl_state_sts[4*c +: 4]             = sts_p1;
    assign err_cnt[ERR_CNT_W*c +: ERR_CNT_W]  = err_p1;
  end

endmodule

// File: tb/tb_ucie_rdi_state_hs_mc.sv
// Bench for ucie_rdi_state_hs_mc: per-cycle scoreboard fed by a behavioural channel model,
// plus scenario tasks with targeted checks.
module tb_ucie_rdi_state_hs_mc;
  localparam int NCH = 4;
  localparam int TMO = 16;
  localparam int EW  = 8;

  localparam logic [3:0] R_RESET = 4'h0, R_ACTIVE = 4'h1, R_L1 = 4'h4, R_L2 = 4'h8;
  localparam logic [3:0] R_LINKRESET = 4'h9, R_LINKERROR = 4'hA, R_RETRAIN = 4'hB;
  localparam int P_RESET = 0, P_ACTIVE = 1, P_SREQ = 2, P_SREL = 3, P_PARK = 4, P_ERR = 5;

  logic clk, reset;
  logic [4*NCH-1:0]  lp_state_req;
  logic [NCH-1:0]    lp_stallack, phy_link_up, phy_link_err;
  logic [NCH-1:0]    pl_stallreq, link_up, stall_busy, timeout_pulse;
  logic [4*NCH-1:0]  pl_state_sts;
  logic [EW*NCH-1:0] err_cnt;

  int checks = 0;
  int failures = 0;

  ucie_rdi_state_hs_mc #(.NUM_CH(NCH), .STALL_TIMEOUT(TMO), .ERR_CNT_W(EW)) dut (
    .clk(clk), .reset(reset), .lp_state_req(lp_state_req), .lp_stallack(lp_stallack),
    .phy_link_up(phy_link_up), .phy_link_err(phy_link_err), .pl_stallreq(pl_stallreq),
    .pl_state_sts(pl_state_sts), .link_up(link_up), .stall_busy(stall_busy),
    .timeout_pulse(timeout_pulse), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model + scoreboard ----------------
  int m_st[NCH], m_tgt[NCH], m_tmr[NCH], m_err[NCH];
  bit m_tmo[NCH];
  logic [63:0] sb[$];

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = P_RESET; m_tgt[c] = 0; m_tmr[c] = 0; m_err[c] = 0; m_tmo[c] = 0;
    end
  endtask

  task automatic model_step(input int c, input logic [3:0] rq, input logic ak,
                            input logic up, input logic er);
    int prev;
    prev = m_st[c];
    m_tmo[c] = 0;
    if (er && prev != P_RESET && prev != P_ERR) m_st[c] = P_ERR;
    else if (prev == P_RESET) begin
      if (rq == R_ACTIVE && up && !er) m_st[c] = P_ACTIVE;
    end else if (prev == P_ACTIVE) begin
      if (rq == R_L1 || rq == R_L2 || rq == R_LINKRESET || rq == R_RETRAIN) begin
        m_tgt[c] = rq; m_tmr[c] = 0; m_st[c] = P_SREQ;
      end else if (!up) begin
        m_tgt[c] = R_RETRAIN; m_tmr[c] = 0; m_st[c] = P_SREQ;
      end
    end else if (prev == P_SREQ || prev == P_SREL) begin
      if ((prev == P_SREQ && ak) || (prev == P_SREL && !ak)) begin
        m_st[c] = (prev == P_SREQ) ? P_SREL : P_PARK;
        m_tmr[c] = 0;
      end else if (m_tmr[c] == TMO - 1) begin
        m_st[c] = P_ERR; m_tmo[c] = 1;
      end else m_tmr[c]++;
    end else if (prev == P_PARK) begin
      if (m_tgt[c] == R_L1 || m_tgt[c] == R_RETRAIN) begin
        if (rq == R_ACTIVE && up) m_st[c] = P_ACTIVE;
      end else if (rq == R_RESET) m_st[c] = P_RESET;
    end else if (prev == P_ERR) begin
      if (rq == R_RESET && !er) m_st[c] = P_RESET;
    end
    if (m_st[c] == P_ERR && prev != P_ERR && m_err[c] < (1 << EW) - 1) m_err[c]++;
  endtask

  function automatic logic [63:0] model_pack();
    logic [3:0] sr, lu, bz, to;
    logic [15:0] ss;
    logic [31:0] ec;
    logic [3:0] s;
    for (int c = 0; c < NCH; c++) begin
      case (m_st[c])
        P_ACTIVE, P_SREQ, P_SREL: s = R_ACTIVE;
        P_PARK:                   s = 4'(m_tgt[c]);
        P_ERR:                    s = R_LINKERROR;
        default:                  s = R_RESET;
      endcase
      ss[4*c +: 4] = s;
      sr[c] = (m_st[c] == P_SREQ);
      bz[c] = (m_st[c] == P_SREQ) || (m_st[c] == P_SREL);
      lu[c] = (s == R_ACTIVE);
      to[c] = m_tmo[c];
      ec[8*c +: 8] = 8'(m_err[c]);
    end
    return {sr, ss, lu, bz, to, ec};
  endfunction

  initial begin
    model_clear();
    sb.push_back('0);
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_clear();
        sb.delete();
        sb.push_back('0);
      end else begin
        for (int c = 0; c < NCH; c++)
          model_step(c, lp_state_req[4*c +: 4], lp_stallack[c], phy_link_up[c], phy_link_err[c]);
        sb.push_back(model_pack());
      end
    end
  end

  initial begin
    logic [63:0] act, exp_v;
    forever begin
      @(negedge clk);
      if (!reset && sb.size() >= 2) begin
        exp_v = sb.pop_front();
        act = {pl_stallreq, pl_state_sts, link_up, stall_busy, timeout_pulse, err_cnt};
        checks++;
        if (act !== exp_v) begin
          failures++;
          $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, act, exp_v);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({pl_stallreq, pl_state_sts, link_up, stall_busy, timeout_pulse, err_cnt} !== 64'h0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=0",
               {pl_stallreq, pl_state_sts, link_up, stall_busy, timeout_pulse, err_cnt});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pl_state_sts !== 16'h0) begin
      failures++; $display("FAIL idle_after_reset sts=%h required=0000", pl_state_sts);
    end
  endtask

  task automatic test_activate();
    phy_link_up[0] = 1'b1;
    lp_state_req[3:0] = R_ACTIVE;
    @(negedge clk);
    checks++;
    if (pl_state_sts[3:0] !== R_RESET) begin
      failures++; $display("FAIL act_latency sts0=%h required=0", pl_state_sts[3:0]);
    end
    @(negedge clk);
    checks++;
    if (pl_state_sts !== 16'h0001 || link_up !== 4'b0001) begin
      failures++; $display("FAIL act_ch0 sts=%h link_up=%b required sts=0001 link_up=0001", pl_state_sts, link_up);
    end
  endtask

  task automatic test_l1_handshake();
    int n, hi;
    phy_link_up[1] = 1'b1;
    lp_state_req[7:4] = R_ACTIVE;
    repeat (3) @(negedge clk);
    lp_state_req[7:4] = R_L1;
    n = 0;
    while (!pl_stallreq[1] && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL l1_stallreq_rise actual=0 required=1"); end
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      if (hi == 3) begin
        lp_stallack[1] = 1'b1;
        lp_state_req[7:4] = R_L2;
      end
      @(negedge clk);
      if (pl_stallreq[1]) hi++; else break;
    end
    checks++;
    if (hi != 4) begin failures++; $display("FAIL l1_stallreq_width actual=%0d required=4", hi); end
    lp_stallack[1] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pl_state_sts[7:4] !== R_L1 || stall_busy[1] !== 1'b0) begin
      failures++; $display("FAIL l1_parked sts1=%h busy=%b required sts1=4 busy=0", pl_state_sts[7:4], stall_busy[1]);
    end
    lp_state_req[7:4] = R_ACTIVE;
    repeat (2) @(negedge clk);
    checks++;
    if (pl_state_sts[7:4] !== R_ACTIVE) begin
      failures++; $display("FAIL l1_resume sts1=%h required=1", pl_state_sts[7:4]);
    end
  endtask

  task automatic test_timeout();
    int n, cyc;
    phy_link_up[2] = 1'b1;
    lp_state_req[11:8] = R_ACTIVE;
    repeat (3) @(negedge clk);
    lp_state_req[11:8] = R_RETRAIN;
    n = 0;
    while (!pl_stallreq[2] && n < 20) begin @(negedge clk); n++; end
    cyc = 0;
    while (!timeout_pulse[2] && cyc < 40) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != TMO) begin failures++; $display("FAIL tmo_cycle actual=%0d required=%0d", cyc, TMO); end
    checks++;
    if (pl_state_sts[11:8] !== R_LINKERROR || err_cnt[23:16] !== 8'd1 || pl_stallreq[2] !== 1'b0) begin
      failures++;
      $display("FAIL tmo_error sts2=%h err2=%0d stallreq=%b required A/1/0", pl_state_sts[11:8], err_cnt[23:16], pl_stallreq[2]);
    end
    @(negedge clk);
    checks++;
    if (timeout_pulse[2] !== 1'b0) begin failures++; $display("FAIL tmo_pulse_width actual=1 required=0"); end
    lp_state_req[11:8] = R_RESET;
    repeat (2) @(negedge clk);
    checks++;
    if (pl_state_sts[11:8] !== R_RESET) begin
      failures++; $display("FAIL tmo_recover sts2=%h required=0", pl_state_sts[11:8]);
    end
  endtask

  task automatic test_error_escalation();
    int n;
    phy_link_up[3] = 1'b1;
    lp_state_req[15:12] = R_ACTIVE;
    repeat (3) @(negedge clk);
    lp_state_req[15:12] = R_L2;
    n = 0;
    while (!pl_stallreq[3] && n < 20) begin @(negedge clk); n++; end
    phy_link_err[3] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pl_stallreq[3] !== 1'b0 || pl_state_sts[15:12] !== R_LINKERROR || err_cnt[31:24] !== 8'd1) begin
      failures++;
      $display("FAIL err_entry stallreq=%b sts3=%h err3=%0d required 0/A/1", pl_stallreq[3], pl_state_sts[15:12], err_cnt[31:24]);
    end
    for (int i = 0; i < 259; i++) begin
      phy_link_err[3] = 1'b0; lp_state_req[15:12] = R_RESET;
      repeat (2) @(negedge clk);
      lp_state_req[15:12] = R_ACTIVE;
      repeat (2) @(negedge clk);
      phy_link_err[3] = 1'b1;
      repeat (2) @(negedge clk);
    end
    checks++;
    if (err_cnt[31:24] !== 8'd255 || err_cnt[23:16] !== 8'd1) begin
      failures++; $display("FAIL err_saturate err3=%0d err2=%0d required 255/1", err_cnt[31:24], err_cnt[23:16]);
    end
    phy_link_err[3] = 1'b0; lp_state_req[15:12] = R_RESET;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_boundary_and_reset();
    int n, cyc;
    lp_state_req[3:0] = R_LINKRESET;
    n = 0;
    while (!pl_stallreq[0] && n < 20) begin @(negedge clk); n++; end
    cyc = 0;
    while (cyc < TMO - 2) begin @(negedge clk); cyc++; end
    lp_stallack[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (timeout_pulse[0] !== 1'b0 || pl_stallreq[0] !== 1'b0 || stall_busy[0] !== 1'b1 || err_cnt[7:0] !== 8'd0) begin
      failures++;
      $display("FAIL ack_at_limit tmo=%b stallreq=%b busy=%b err0=%0d required 0/0/1/0",
               timeout_pulse[0], pl_stallreq[0], stall_busy[0], err_cnt[7:0]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pl_stallreq, pl_state_sts, link_up, stall_busy, timeout_pulse, err_cnt} !== 64'h0) begin
      failures++;
      $display("FAIL async_reset actual=%h required=0",
               {pl_stallreq, pl_state_sts, link_up, stall_busy, timeout_pulse, err_cnt});
    end
    @(negedge clk);
    lp_stallack = '0; lp_state_req = '0; phy_link_err = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pl_state_sts !== 16'h0 || err_cnt !== 32'h0) begin
      failures++; $display("FAIL post_reset sts=%h err=%h required 0/0", pl_state_sts, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int d_up[NCH], d_dn[NCH], cnt[NCH];
    phy_link_up = 4'hF;
    lp_state_req = 16'h1111;
    repeat (3) @(negedge clk);
    checks++;
    if (link_up !== 4'hF) begin failures++; $display("FAIL b2b_active link_up=%b required=1111", link_up); end
    for (int c = 0; c < NCH; c++) begin
      d_up[c] = int'($urandom_range(1, 6)); d_dn[c] = int'($urandom_range(1, 4)); cnt[c] = 0;
    end
    lp_state_req = 16'hB984;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (pl_stallreq[c] && !lp_stallack[c]) begin
          cnt[c]++;
          if (cnt[c] >= d_up[c]) begin lp_stallack[c] = 1'b1; cnt[c] = 0; end
        end else if (lp_stallack[c] && !pl_stallreq[c]) begin
          cnt[c]++;
          if (cnt[c] >= d_dn[c]) begin lp_stallack[c] = 1'b0; cnt[c] = 0; end
        end
      end
      if (pl_state_sts == 16'hB984 && stall_busy == 4'h0) break;
    end
    checks++;
    if (pl_state_sts !== 16'hB984 || err_cnt !== 32'h0) begin
      failures++; $display("FAIL b2b_parked sts=%h err=%h required B984/0", pl_state_sts, err_cnt);
    end
    lp_state_req = 16'h1001;
    repeat (3) @(negedge clk);
    checks++;
    if (pl_state_sts !== 16'h1001 || link_up !== 4'b1001) begin
      failures++; $display("FAIL b2b_release sts=%h link_up=%b required 1001/1001", pl_state_sts, link_up);
    end
  endtask

  task automatic test_link_drop();
    int n;
    phy_link_up[0] = 1'b0;
    n = 0;
    while (!pl_stallreq[0] && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL drop_stallreq actual=0 required=1"); end
    lp_stallack[0] = 1'b1;
    n = 0;
    while (pl_stallreq[0] && n < 20) begin @(negedge clk); n++; end
    lp_stallack[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pl_state_sts[3:0] !== R_RETRAIN || link_up[0] !== 1'b0) begin
      failures++; $display("FAIL drop_retrain sts0=%h link_up0=%b required B/0", pl_state_sts[3:0], link_up[0]);
    end
  endtask

  initial begin
    reset = 1'b1;
    lp_state_req = '0; lp_stallack = '0; phy_link_up = '0; phy_link_err = '0;
    test_reset();
    test_activate();
    test_l1_handshake();
    test_timeout();
    test_error_escalation();
    test_boundary_and_reset();
    test_back_to_back();
    test_link_drop();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
